// File: rtl/seq_mult_bcd.sv
// rtl/seq_mult_bcd.sv - signed shift-add multiplier with double-dabble BCD and scrollable digit window
// Define SEQ_MULT_BLANK_EN to show leading zero digits as the blank code 4'hF.
module seq_mult_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5,
    parameter int WIN    = 3,
    localparam int WPW   = (DIGITS - WIN + 1 > 1) ? $clog2(DIGITS - WIN + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      mp,
    input  logic [WIDTH-1:0]      mc,
    input  logic                  scroll_l,
    input  logic                  scroll_r,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    product,
    output logic                  sign,
    output logic                  zero,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*WIN-1:0]      win_bcd,
    output logic [WPW-1:0]        win_pos
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0]  MULT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CONV_LAST = CW'(2 * WIDTH - 1);
    localparam logic [WPW-1:0] POS_MAX   = WPW'(DIGITS - WIN);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_CONV, S_DONE} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt;
    logic [2*WIDTH:0]       acc;
    logic [WIDTH-1:0]       mc_mag;
    logic                   sgn;
    logic [WIDTH:0]         mult_sum;
    logic [4*DIGITS-1:0]    work;
    logic [4*DIGITS-1:0]    work_adj;
    logic [4*DIGITS-1:0]    bcd_fmt;
    logic [2*WIDTH-1:0]     mag;
    logic [2*WIDTH-1:0]     mag_neg;
    logic                   res_zero;
    logic                   res_sign;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start)            state_n = S_MULT;
            S_MULT: if (cnt == MULT_LAST) state_n = S_CONV;
            S_CONV: if (cnt == CONV_LAST) state_n = S_DONE;
            S_DONE:                       state_n = S_IDLE;
            default:                      state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_MULT) || (state == S_CONV);

    // Multiplier sits in the low half of acc; partial sums build up in the upper half.
    assign mult_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mc_mag} : {(WIDTH+1){1'b0}});
    assign mag      = acc[2*WIDTH-1:0];
    assign mag_neg  = ~mag + {{(2*WIDTH-1){1'b0}}, 1'b1};
    assign res_zero = ~|mag;
    assign res_sign = sgn & ~res_zero;

    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

`ifdef SEQ_MULT_BLANK_EN
    logic lead;
    always_comb begin
        bcd_fmt = work;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (work[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead) bcd_fmt[4*i +: 4] = 4'hF;
        end
    end
`else
    assign bcd_fmt = work;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            mc_mag  <= '0;
            sgn     <= 1'b0;
            work    <= '0;
            done    <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
            zero    <= 1'b0;
            bcd     <= '0;
            win_pos <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= {1'b0, {WIDTH{1'b0}}, abs_w(mp)};
                        mc_mag <= abs_w(mc);
                        sgn    <= mp[WIDTH-1] ^ mc[WIDTH-1];
                        cnt    <= '0;
                        work   <= '0;
                    end
                    if (scroll_l && !scroll_r && win_pos != POS_MAX)
                        win_pos <= win_pos + 1'b1;
                    else if (scroll_r && !scroll_l && win_pos != '0)
                        win_pos <= win_pos - 1'b1;
                end
                S_MULT: begin
                    acc <= {1'b0, mult_sum, acc[WIDTH-1:1]};
                    cnt <= (cnt == MULT_LAST) ? '0 : cnt + 1'b1;
                end
                S_CONV: begin
                    // Rotate the magnitude so it is intact again after 2*WIDTH steps.
                    work <= {work_adj[4*DIGITS-2:0], acc[2*WIDTH-1]};
                    acc  <= {acc[2*WIDTH], acc[2*WIDTH-2:0], acc[2*WIDTH-1]};
                    cnt  <= cnt + 1'b1;
                end
                S_DONE: begin
                    product <= res_sign ? mag_neg : mag;
                    sign    <= res_sign;
                    zero    <= res_zero;
                    bcd     <= bcd_fmt;
                    done    <= 1'b1;
                    win_pos <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        win_bcd = '0;
        for (int k = 0; k <= DIGITS - WIN; k++) begin
            if (win_pos == WPW'(k)) win_bcd = bcd[4*k +: 4*WIN];
        end
    end

endmodule
